// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory fill arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_arb_pkg;

  localparam int WORDS      = 8;   // 16-bit words per cache block
  localparam int WORD_IDX_W = 3;   // log2(WORDS)

  // Clearing these bits of a byte address gives the block base address.
  localparam logic [15:0] BLOCK_OFFSET_MASK = 16'h000F;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_FILL_I = 3'd2,
    ST_FILL_D = 3'd3,
    ST_DONE_I = 3'd4,
    ST_DONE_D = 3'd5
  } arb_state_e;

endpackage

// File: rtl/mem_fill_arbiter_fill_sequencer.sv
// Block fill sequencer: issue and receive counters plus read address generation.
// Latency: the first read issues in the cycle after start_i; the receive side follows mem_rvalid_i.
// Backpressure: none; issues one read per active cycle with no gaps and accepts every rvalid.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start_i        grant edge: clear counters, latch base_i
//   active_i       arbiter is in a fill state
//   base_i         block base byte address
//   mem_rvalid_i   memory read data valid
//   issue_en_o     issue a read this cycle
//   issue_addr_o   byte address of the read
//   rx_we_o        a fill word arrives this cycle
//   rx_idx_o       word index of the arriving word
//   last_o         this arrival is the final word of the block
module fill_sequencer #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              active_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              mem_rvalid_i,
  output logic              issue_en_o,
  output logic [ADDR_W-1:0] issue_addr_o,
  output logic              rx_we_o,
  output logic [IDX_W-1:0]  rx_idx_o,
  output logic              last_o
);

  // The issue counter must be able to hold WORDS itself to mark "all issued".
  localparam int CNT_W = $clog2(WORDS + 1);

  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [IDX_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;

  always_comb begin
    issue_en_o   = active_i && (issue_cnt_q < CNT_W'(WORDS));
    issue_addr_o = base_q + (ADDR_W'(issue_cnt_q) << 1);
    rx_we_o      = active_i && mem_rvalid_i;
    rx_idx_o     = rx_cnt_q;
    last_o       = rx_we_o && (rx_cnt_q == IDX_W'(WORDS - 1));
  end

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    base_d      = base_q;
    if (start_i) begin
      issue_cnt_d = '0;
      rx_cnt_d    = '0;
      base_d      = base_i;
    end else begin
      if (issue_en_o) begin
        issue_cnt_d = issue_cnt_q + CNT_W'(1);
      end
      if (rx_we_o) begin
        rx_cnt_d = last_o ? '0 : rx_cnt_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
      base_q      <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      base_q      <= base_d;
    end
  end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates the unified data memory between I-fill, D-fill and D write-through stores.
// Latency: grant registered (1 cycle); block fill = 8 issues, done pulse after the 8th word returns.
// Backpressure: requesters hold req until ack/done; losers wait in IDLE arbitration.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   ic_miss_req/addr                 I-cache miss request (held until ic_fill_done)
//   dc_miss_req/addr                 D-cache miss request (held until dc_fill_done)
//   dc_wr_req/addr/data, dc_wr_ack   D-cache write-through store, ack pulse on issue
//   ic_fill_we, dc_fill_we           per-cache fill word write strobes
//   fill_word_idx, fill_data         word index / data for the fill write
//   ic_fill_done, dc_fill_done       one-cycle block-complete pulses
//   busy                             arbiter not idle
//   mem_en/wr/addr/wdata             memory request port
//   mem_rdata, mem_rvalid            memory read return (fixed latency)
module mem_fill_arbiter #(
  parameter int WORDS  = mem_arb_pkg::WORDS,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ic_miss_req,
  input  logic [ADDR_W-1:0]        ic_miss_addr,
  input  logic                     dc_miss_req,
  input  logic [ADDR_W-1:0]        dc_miss_addr,
  input  logic                     dc_wr_req,
  input  logic [ADDR_W-1:0]        dc_wr_addr,
  input  logic [DATA_W-1:0]        dc_wr_data,
  output logic                     dc_wr_ack,
  output logic                     ic_fill_we,
  output logic                     dc_fill_we,
  output logic [$clog2(WORDS)-1:0] fill_word_idx,
  output logic [DATA_W-1:0]        fill_data,
  output logic                     ic_fill_done,
  output logic                     dc_fill_done,
  output logic                     busy,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_rvalid
);

  import mem_arb_pkg::*;

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(BLOCK_OFFSET_MASK);

  arb_state_e state_q, state_d;
  logic       fair_q, fair_d;  // I-cache gets the next IDLE grant after it waited behind D

  logic              seq_start;
  logic              seq_active;
  logic [ADDR_W-1:0] seq_base;
  logic              seq_issue_en;
  logic [ADDR_W-1:0] seq_issue_addr;
  logic              seq_rx_we;
  logic [IDX_W-1:0]  seq_rx_idx;
  logic              seq_last;

  assign seq_active = (state_q == ST_FILL_I) || (state_q == ST_FILL_D);

  fill_sequencer #(
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_fill_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (seq_start),
    .active_i     (seq_active),
    .base_i       (seq_base),
    .mem_rvalid_i (mem_rvalid),
    .issue_en_o   (seq_issue_en),
    .issue_addr_o (seq_issue_addr),
    .rx_we_o      (seq_rx_we),
    .rx_idx_o     (seq_rx_idx),
    .last_o       (seq_last)
  );

  always_comb begin
    state_d      = state_q;
    fair_d       = fair_q;
    seq_start    = 1'b0;
    seq_base     = '0;
    dc_wr_ack    = 1'b0;
    ic_fill_we   = 1'b0;
    dc_fill_we   = 1'b0;
    ic_fill_done = 1'b0;
    dc_fill_done = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (fair_q && ic_miss_req) begin
          state_d   = ST_FILL_I;
          seq_start = 1'b1;
          seq_base  = ic_miss_addr & BASE_MASK;
          fair_d    = 1'b0;
        end else if (dc_wr_req) begin
          state_d = ST_WRITE;
        end else if (dc_miss_req) begin
          state_d   = ST_FILL_D;
          seq_start = 1'b1;
          seq_base  = dc_miss_addr & BASE_MASK;
        end else if (ic_miss_req) begin
          state_d   = ST_FILL_I;
          seq_start = 1'b1;
          seq_base  = ic_miss_addr & BASE_MASK;
          fair_d    = 1'b0;
        end
      end

      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = dc_wr_addr;
        mem_wdata = dc_wr_data;
        dc_wr_ack = 1'b1;
        state_d   = ST_IDLE;
        if (ic_miss_req) begin
          fair_d = 1'b1;
        end
      end

      ST_FILL_I: begin
        mem_en     = seq_issue_en;
        mem_addr   = seq_issue_en ? seq_issue_addr : '0;
        ic_fill_we = seq_rx_we;
        if (seq_last) begin
          state_d = ST_DONE_I;
        end
      end

      ST_FILL_D: begin
        mem_en     = seq_issue_en;
        mem_addr   = seq_issue_en ? seq_issue_addr : '0;
        dc_fill_we = seq_rx_we;
        if (seq_last) begin
          state_d = ST_DONE_D;
          if (ic_miss_req) begin
            fair_d = 1'b1;
          end
        end
      end

      ST_DONE_I: begin
        ic_fill_done = 1'b1;
        state_d      = ST_IDLE;
      end

      ST_DONE_D: begin
        dc_fill_done = 1'b1;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Fill word fields are gated so they read zero whenever no fill write happens.
  assign fill_word_idx = seq_rx_we ? seq_rx_idx : '0;
  assign fill_data     = seq_rx_we ? mem_rdata : '0;
  assign busy          = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fair_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fair_q  <= fair_d;
    end
  end

endmodule
